// File: rtl/aes_uart_packer.sv
// Serialises one latched AES block onto a byte-wide UART transmitter, MSB byte first,
// using the transmitter's start/ready handshake.
module aes_uart_packer #(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_BYTES-1:0] blk_in,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned BlkW = 8 * NUM_BYTES;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [BlkW-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (blk_valid) begin
          shift_d = blk_in;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (tx_ready) begin
          tx_data_d  = shift_q[BlkW-1 -: 8];
          tx_start_d = 1'b1;
          shift_d    = shift_q << 8;
          state_d    = StWaitAck;
        end
      end
      // tx_ready still reads idle during the start cycle; wait for it to drop first
      StWaitAck: begin
        if (!tx_ready) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (tx_ready) begin
          if (cnt_q == LastIdx) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign blk_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign done      = done_q;

endmodule
